// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encodings and PCSelect codes for the fetch controller
package fetch_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_HALT      = 3'd3,
    ST_LOAD_INIT = 3'd4,
    ST_LOAD      = 3'd5
  } state_e;

  localparam logic [1:0] PCSEL_INC1 = 2'b00;
  localparam logic [1:0] PCSEL_INC2 = 2'b01;
  localparam logic [1:0] PCSEL_JR   = 2'b10;
  localparam logic [1:0] PCSEL_BASE = 2'b11;

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch controller bus: decode handshake, program load stream, datapath controls
interface fetch_controller_if;
  import fetch_pkg::*;

  logic              start;
  logic [WORD_W-1:0] im_data;
  logic              dec_ready;
  logic              redirect;
  logic [1:0]        redirect_sel;
  logic              halt;
  logic              load_req;
  logic              load_valid;
  logic              load_last;
  logic [WORD_W-1:0] load_data;
  logic              load_ready;
  logic [WORD_W-1:0] ir;
  logic              ir_valid;
  logic              PCWrite;
  logic              IMWrite;
  logic [1:0]        PCSelect;
  logic [WORD_W-1:0] im_wdata;
  logic [2:0]        state_o;

  modport master (
    input  start, im_data, dec_ready, redirect, redirect_sel, halt,
           load_req, load_valid, load_last, load_data,
    output load_ready, ir, ir_valid, PCWrite, IMWrite, PCSelect, im_wdata, state_o
  );

  modport slave (
    output start, im_data, dec_ready, redirect, redirect_sel, halt,
           load_req, load_valid, load_last, load_data,
    input  load_ready, ir, ir_valid, PCWrite, IMWrite, PCSelect, im_wdata, state_o
  );

endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with decode handshake and program-load mode
module fetch_controller
  import fetch_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  fetch_controller_if.master bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              irv_q, irv_d;

  logic              pc_write;
  logic              im_write;
  logic [1:0]        pc_sel;
  logic              load_ready;
  logic [WORD_W-1:0] im_wdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      irv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
    end
  end

  // Datapath controls are pure decodes of state and inputs so a reset drops them at once.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    irv_d      = irv_q;
    pc_write   = 1'b0;
    im_write   = 1'b0;
    pc_sel     = PCSEL_INC1;
    load_ready = 1'b0;
    im_wdata   = '0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.load_req) begin
          state_d = ST_LOAD_INIT;
        end else if (bus.start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = bus.im_data;
        irv_d   = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.dec_ready) begin
          irv_d = 1'b0;
          if (bus.halt) begin
            state_d = ST_HALT;
          end else begin
            pc_write = 1'b1;
            pc_sel   = bus.redirect ? bus.redirect_sel : PCSEL_INC1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_LOAD_INIT: begin
        ir_d     = '0;
        pc_write = 1'b1;
        pc_sel   = PCSEL_BASE;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          // Write lands at the current PC while the PC steps to the next slot.
          im_write = 1'b1;
          pc_write = 1'b1;
          pc_sel   = PCSEL_INC1;
          im_wdata = bus.load_data;
          if (bus.load_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ir         = ir_q;
  assign bus.ir_valid   = irv_q;
  assign bus.PCWrite    = pc_write;
  assign bus.IMWrite    = im_write;
  assign bus.PCSelect   = pc_sel;
  assign bus.load_ready = load_ready;
  assign bus.im_wdata   = im_wdata;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed and randomized checks of fetch_controller against a reference model
module tb_fetch_controller;
  import fetch_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  fetch_controller_if bus ();
  fetch_controller dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  state_e      m_st;
  logic [15:0] m_ir;
  logic        m_irv;
  logic        e_pcw, e_imw, e_lr;
  logic [1:0]  e_sel;
  logic [15:0] e_wd;

  // Datapath model driven by what the DUT actually asserts
  int          pc = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] sent [$];
  logic        o_pcw, o_imw;
  logic [1:0]  o_sel;
  logic [15:0] o_wd;

  task automatic model_reset();
    m_st  = ST_IDLE;
    m_ir  = '0;
    m_irv = 1'b0;
    sent.delete();
  endtask

  task automatic model_outputs();
    e_pcw = 1'b0; e_imw = 1'b0; e_lr = 1'b0; e_sel = PCSEL_INC1; e_wd = '0;
    if (m_st == ST_ISSUE && bus.dec_ready && !bus.halt) begin
      e_pcw = 1'b1;
      e_sel = bus.redirect ? bus.redirect_sel : PCSEL_INC1;
    end else if (m_st == ST_LOAD_INIT) begin
      e_pcw = 1'b1;
      e_sel = PCSEL_BASE;
    end else if (m_st == ST_LOAD) begin
      e_lr = 1'b1;
      if (bus.load_valid) begin
        e_imw = 1'b1;
        e_pcw = 1'b1;
        e_wd  = bus.load_data;
      end
    end
  endtask

  task automatic datapath_update();
    if (o_imw) mem[pc] = o_wd;
    if (o_pcw) begin
      case (o_sel)
        2'b00:   pc = (pc + 1) & 16'hFFFF;
        2'b01:   pc = (pc + 2) & 16'hFFFF;
        2'b10:   pc = 16'h0100;
        default: pc = 0;
      endcase
    end
  endtask

  task automatic model_update();
    case (m_st)
      ST_IDLE, ST_HALT: begin
        if (bus.load_req) m_st = ST_LOAD_INIT;
        else if (bus.start) m_st = ST_FETCH;
      end
      ST_FETCH: begin
        m_ir  = bus.im_data;
        m_irv = 1'b1;
        m_st  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.dec_ready) begin
          m_irv = 1'b0;
          m_st  = bus.halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_LOAD_INIT: begin
        m_ir = '0;
        sent.delete();
        m_st = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          sent.push_back(bus.load_data);
          if (bus.load_last) begin
            for (int k = 0; k < sent.size(); k++)
              check_eq($sformatf("loadmem[%0d]", k), mem[k], sent[k]);
            m_st = ST_IDLE;
          end
        end
      end
      default: m_st = ST_IDLE;
    endcase
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    if (!RST_N) model_reset();
    model_outputs();
    check_eq("state_o",    bus.state_o, m_st);
    check_eq("ir",         bus.ir, m_ir);
    check_eq("ir_valid",   bus.ir_valid, m_irv);
    check_eq("PCWrite",    bus.PCWrite, e_pcw);
    check_eq("IMWrite",    bus.IMWrite, e_imw);
    check_eq("PCSelect",   bus.PCSelect, e_sel);
    check_eq("load_ready", bus.load_ready, e_lr);
    check_eq("im_wdata",   bus.im_wdata, e_wd);
    o_pcw = bus.PCWrite; o_imw = bus.IMWrite; o_sel = bus.PCSelect; o_wd = bus.im_wdata;
    @(posedge CLK);
    if (RST_N) begin
      datapath_update();
      model_update();
    end
    @(negedge CLK);
  endtask

  task automatic drive(input logic s, input logic dr, input logic rd, input logic [1:0] rs,
                       input logic h, input logic lrq, input logic lv, input logic ll,
                       input logic [15:0] imd, input logic [15:0] ld);
    bus.start = s; bus.dec_ready = dr; bus.redirect = rd; bus.redirect_sel = rs;
    bus.halt = h; bus.load_req = lrq; bus.load_valid = lv; bus.load_last = ll;
    bus.im_data = imd; bus.load_data = ld;
  endtask

  initial begin
    RST_N = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0);
    model_reset();
    @(negedge CLK);
    step();
    RST_N = 1'b1;

    // Basic fetch and issue
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h1234, 16'h0); step();
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h1234, 16'h0); step();
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0);
    #1;
    check_eq("d035_ir", bus.ir, 16'h1234);
    check_eq("d035_irv", bus.ir_valid, 1'b1);
    check_eq("d035_pcw", bus.PCWrite, 1'b1);
    check_eq("d035_sel", bus.PCSelect, PCSEL_INC1);
    step();

    // Decode stall for five cycles
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h5678, 16'h0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 2'b10, 1, 0, 0, 0, 16'h0bad, 16'h0);
      #1;
      check_eq("d036_ir", bus.ir, 16'h5678);
      check_eq("d036_pcw", bus.PCWrite, 1'b0);
      step();
    end
    drive(0, 1, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0);
    #1;
    check_eq("d036_hs", bus.PCWrite, 1'b1);
    step();

    // Redirect, then halt overriding redirect
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h9abc, 16'h0); step();
    drive(0, 1, 1, PCSEL_JR, 0, 0, 0, 0, 16'h0, 16'h0);
    #1;
    check_eq("d037_pcw", bus.PCWrite, 1'b1);
    check_eq("d037_sel", bus.PCSelect, PCSEL_JR);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h4321, 16'h0); step();
    drive(0, 1, 1, PCSEL_INC2, 1, 0, 0, 0, 16'h0, 16'h0);
    #1;
    check_eq("d037_halt_pcw", bus.PCWrite, 1'b0);
    step();
    #1;
    check_eq("d037_halt_st", bus.state_o, ST_HALT);

    // Program load with a gap cycle
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0, 16'h0, 16'h0); step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0);
    #1;
    check_eq("d038_init_st", bus.state_o, ST_LOAD_INIT);
    check_eq("d038_init_sel", bus.PCSelect, PCSEL_BASE);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0, 16'hA001);
    #1; check_eq("d038_w1", bus.IMWrite ? bus.im_wdata : 16'h0, 16'hA001); step();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0, 16'hA002);
    #1; check_eq("d038_w2", bus.IMWrite ? bus.im_wdata : 16'h0, 16'hA002); step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'hFFFF);
    #1; check_eq("d038_gap", bus.IMWrite, 1'b0); step();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0, 16'hA003);
    #1; check_eq("d038_w3", bus.IMWrite ? bus.im_wdata : 16'h0, 16'hA003); step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0);
    #1; check_eq("d038_done", bus.state_o, ST_IDLE);

    // Asynchronous reset in the middle of a load write
    step();
    drive(0, 0, 0, 2'b00, 0, 1, 0, 0, 16'h0, 16'h0); step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0); step();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0, 16'hBEEF);
    #1; check_eq("d039_pre", bus.IMWrite, 1'b1);
    #1; RST_N = 1'b0;
    #1;
    check_eq("d039_imw", bus.IMWrite, 1'b0);
    check_eq("d039_pcw", bus.PCWrite, 1'b0);
    check_eq("d039_st", bus.state_o, ST_IDLE);
    step();
    RST_N = 1'b1;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      RST_N = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1), $urandom_range(0, 3) == 0,
            16'($urandom), 16'($urandom));
      step();
    end
    RST_N = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
